// File: rtl/btn_sampler_pkg.sv
// Shared types and defaults for the push-button serial sampler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package btn_sampler_pkg;

    // Debounce FSM states; encoding is fixed so other tools can decode it.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHK_HIGH    = 2'd1,
        STABLE_HIGH = 2'd2,
        CHK_LOW     = 2'd3
    } deb_state_t;

    localparam int DEF_TICK_DIV      = 67108864;
    localparam int DEF_DEB_CYCLES    = 1000000;
    localparam int DEF_BITS_PER_WORD = 8;

endpackage

// File: rtl/btn_serial_sampler_tick_gen.sv
// Free-running divider: tick is high during the last clk cycle of every DIV-cycle period.
// Latency: tick is combinational from the counter; first tick in cycle DIV-1 after reset.
// Backpressure: none, always counts.
module tick_gen #(
    parameter int DIV = 67108864
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..DIV-1 and wrap; equality compare keeps it exact for non-power-of-two DIV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/btn_serial_sampler.sv
// Button front end: sync + debounce btn, emit one stable serial bit per slow strobe, track word position.
// Latency: btn edge to btn_stable is 2+DEB_CYCLES edges; shift_en/sdi/bit_idx/word_done register on the tick edge.
// Backpressure: none; downstream SIPO must accept sdi on every shift_en.
module btn_serial_sampler
    import btn_sampler_pkg::*;
#(
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int BITS_PER_WORD = DEF_BITS_PER_WORD
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             btn,
    output logic                             btn_stable,
    output logic                             sdi,
    output logic                             shift_en,
    output logic [$clog2(BITS_PER_WORD)-1:0] bit_idx,
    output logic                             word_done
);

    localparam int               IDX_W    = $clog2(BITS_PER_WORD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS_PER_WORD - 1);
    // At least one bit so the CHK entry value of 1 always fits, even for DEB_CYCLES=1.
    localparam int               DW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          sync_q1;
    logic          btn_s;
    deb_state_t    state;
    deb_state_t    state_nxt;
    logic [DW-1:0] deb_cnt;
    logic [DW-1:0] deb_cnt_nxt;
    logic          stable_nxt;
    logic          deb_done;
    logic          tick;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            btn_s   <= 1'b0;
        end else begin
            sync_q1 <= btn;
            btn_s   <= sync_q1;
        end
    end

    // The CHK state is entered with deb_cnt=1, so with DEB_CYCLES=1 the count can
    // never equal DEB_CYCLES-1; treat that case as done on the first agreeing sample.
    assign deb_done = (DEB_CYCLES == 1) || (deb_cnt == DEB_LAST);

    // Debounce state, counter and accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= STABLE_LOW;
            deb_cnt    <= '0;
            btn_stable <= 1'b0;
        end else begin
            state      <= state_nxt;
            deb_cnt    <= deb_cnt_nxt;
            btn_stable <= stable_nxt;
        end
    end

    // Debounce next-state: any disagreeing sample in a CHK state returns to the old level.
    always_comb begin
        state_nxt   = state;
        deb_cnt_nxt = deb_cnt;
        stable_nxt  = btn_stable;
        case (state)
            STABLE_LOW: begin
                if (btn_s) begin
                    state_nxt   = CHK_HIGH;
                    deb_cnt_nxt = DW'(1);
                end
            end
            CHK_HIGH: begin
                if (!btn_s) begin
                    state_nxt   = STABLE_LOW;
                    deb_cnt_nxt = '0;
                end else if (deb_done) begin
                    state_nxt   = STABLE_HIGH;
                    stable_nxt  = 1'b1;
                    deb_cnt_nxt = '0;
                end else begin
                    deb_cnt_nxt = deb_cnt + DW'(1);
                end
            end
            STABLE_HIGH: begin
                if (!btn_s) begin
                    state_nxt   = CHK_LOW;
                    deb_cnt_nxt = DW'(1);
                end
            end
            CHK_LOW: begin
                if (btn_s) begin
                    state_nxt   = STABLE_HIGH;
                    deb_cnt_nxt = '0;
                end else if (deb_done) begin
                    state_nxt   = STABLE_LOW;
                    stable_nxt  = 1'b0;
                    deb_cnt_nxt = '0;
                end else begin
                    deb_cnt_nxt = deb_cnt + DW'(1);
                end
            end
        endcase
    end

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Strobe, serial bit and word position all update on the edge that ends a tick period;
    // sdi captures the pre-edge btn_stable so a same-edge debounce change lands next strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_en  <= 1'b0;
            sdi       <= 1'b0;
            bit_idx   <= '0;
            word_done <= 1'b0;
        end else begin
            shift_en  <= tick;
            word_done <= tick && (bit_idx == IDX_LAST);
            if (tick) begin
                sdi     <= btn_stable;
                bit_idx <= bit_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_btn_serial_sampler.sv
module tb_btn_serial_sampler;
    import btn_sampler_pkg::*;

    localparam int TICK = 10;
    localparam int DEB  = 4;
    localparam int BPW  = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic       btn_stable;
    logic       sdi;
    logic       shift_en;
    logic [2:0] bit_idx;
    logic       word_done;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    btn_serial_sampler #(
        .TICK_DIV      (TICK),
        .DEB_CYCLES    (DEB),
        .BITS_PER_WORD (BPW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .btn_stable (btn_stable),
        .sdi        (sdi),
        .shift_en   (shift_en),
        .bit_idx    (bit_idx),
        .word_done  (word_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // btn sampled at edge k is seen by the debouncer at edge k+2; the stable level flips
    // on the DEB-th consecutive disagreeing sample; strobes fall on every TICK-th edge.
    logic m_p1, m_p2, m_stable, m_sdi, m_shift_en, m_word_done;
    int   m_run, m_edges, m_shifts;
    logic [2:0] m_idx;
    assign m_idx = 3'(m_shifts % BPW);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p1 <= 1'b0; m_p2 <= 1'b0; m_stable <= 1'b0; m_sdi <= 1'b0;
            m_shift_en <= 1'b0; m_word_done <= 1'b0;
            m_run <= 0; m_edges <= 0; m_shifts <= 0;
        end else begin
            m_p1 <= btn;
            m_p2 <= m_p1;
            if (m_p2 == m_stable) begin
                m_run <= 0;
            end else if (m_run + 1 == DEB) begin
                m_stable <= m_p2;
                m_run    <= 0;
            end else begin
                m_run <= m_run + 1;
            end
            m_edges <= m_edges + 1;
            if ((m_edges + 1) % TICK == 0) begin
                m_shift_en  <= 1'b1;
                m_sdi       <= m_stable;
                m_shifts    <= m_shifts + 1;
                m_word_done <= ((m_shifts + 1) % BPW == 0);
            end else begin
                m_shift_en  <= 1'b0;
                m_word_done <= 1'b0;
            end
        end
    end

    // Compare every output against the model once per cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_btn_stable", 32'(btn_stable), 32'(m_stable));
            chk("cyc_sdi",        32'(sdi),        32'(m_sdi));
            chk("cyc_shift_en",   32'(shift_en),   32'(m_shift_en));
            chk("cyc_bit_idx",    32'(bit_idx),    32'(m_idx));
            chk("cyc_word_done",  32'(word_done),  32'(m_word_done));
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset(input logic v);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        btn   = v;
        rst_n = 1'b1;
    endtask

    task automatic wait_stable(input logic v, output int lat);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (btn_stable == v) begin
                lat = k;
                return;
            end
        end
    endtask

    task automatic wait_strobe(output logic ok);
        ok = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (shift_en) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    int   lat;
    logic ok;
    int   nstr;
    int   first_wd;
    logic pat     [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int   exp_idx [8] = '{1, 2, 3, 4, 5, 6, 7, 0};
    logic exp_wd  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n  = 1'b0;
        btn    = 1'b1;
        cmp_en = 1'b1;

        // 1: reset with btn high, then first strobe after the 10th edge
        repeat (5) @(negedge clk);
        chk("t1_rst_btn_stable", 32'(btn_stable), 0);
        chk("t1_rst_sdi",        32'(sdi),        0);
        chk("t1_rst_shift_en",   32'(shift_en),   0);
        chk("t1_rst_bit_idx",    32'(bit_idx),    0);
        chk("t1_rst_word_done",  32'(word_done),  0);
        btn   = 1'b0;
        rst_n = 1'b1;
        repeat (9) @(negedge clk);
        chk("t1_no_strobe_edge9", 32'(shift_en), 0);
        @(negedge clk);
        chk("t1_strobe_edge10", 32'(shift_en),  1);
        chk("t1_sdi",           32'(sdi),       0);
        chk("t1_bit_idx",       32'(bit_idx),   1);
        chk("t1_word_done",     32'(word_done), 0);

        // 2: clean edges take 6 edges to reach btn_stable
        btn = 1'b1;
        wait_stable(1'b1, lat);
        chk("t2_rise_latency", 32'(lat), 6);
        btn = 1'b0;
        wait_stable(1'b0, lat);
        chk("t2_fall_latency", 32'(lat), 6);

        // 3: 3-high/2-low bouncing is rejected
        for (int p = 0; p < 12; p++) begin
            btn = 1'b1;
            repeat (3) @(negedge clk);
            btn = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("t3_btn_stable", 32'(btn_stable), 0);
        chk("t3_fsm_state",  32'(dut.state),  32'(STABLE_LOW));

        // 4: one debounced word, bit per strobe
        do_reset(pat[0]);
        for (int i = 0; i < 8; i++) begin
            btn = pat[i];
            wait_strobe(ok);
            chk("t4_strobe_seen", 32'(ok),        1);
            chk("t4_sdi",         32'(sdi),       32'(pat[i]));
            chk("t4_bit_idx",     32'(bit_idx),   32'(exp_idx[i]));
            chk("t4_word_done",   32'(word_done), 32'(exp_wd[i]));
        end

        // 5: mid-word async reset discards the partial word
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            wait_strobe(ok);
            chk("t5_strobe_seen", 32'(ok), 1);
        end
        chk("t5_pre_sdi",     32'(sdi),     1);
        chk("t5_pre_bit_idx", 32'(bit_idx), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_bit_idx",    32'(bit_idx),    0);
        chk("t5_rst_sdi",        32'(sdi),        0);
        chk("t5_rst_btn_stable", 32'(btn_stable), 0);
        @(negedge clk);
        btn   = 1'b0;
        rst_n = 1'b1;
        nstr     = 0;
        first_wd = 0;
        for (int k = 0; k < 120 && first_wd == 0; k++) begin
            @(negedge clk);
            if (shift_en) nstr++;
            if (word_done) first_wd = nstr;
        end
        chk("t5_first_word_done_strobe", 32'(first_wd), 8);

        // 6: btn_stable rises on the strobe edge; sdi picks it up one strobe later
        do_reset(1'b0);
        repeat (14) @(negedge clk);
        btn = 1'b1;
        repeat (6) @(negedge clk);
        chk("t6_strobe_edge20", 32'(shift_en),   1);
        chk("t6_stable_edge20", 32'(btn_stable), 1);
        chk("t6_sdi_edge20",    32'(sdi),        0);
        repeat (10) @(negedge clk);
        chk("t6_strobe_edge30", 32'(shift_en), 1);
        chk("t6_sdi_edge30",    32'(sdi),      1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
